// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizing for the CPU-side RAM access controller.
package mem_ctrl_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MEM_DEPTH = 512;
  localparam int ADDR_BITS     = $clog2(DEF_MEM_DEPTH);
  localparam int CNT_W         = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter whose zero flag ends the strobe phase of an access.
module mem_wait_counter
  import mem_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a combinational word RAM: SETUP, STROBE, HOLD phases.
// Optional macro MEMCTRL_ADDR_CHECK_EN adds addr_err and suppresses out-of-range strobes.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read,
  output logic              mem_write,
`ifdef MEMCTRL_ADDR_CHECK_EN
  output logic              addr_err,
`endif
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam int AW = $clog2(MEM_DEPTH);

  if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait
    $error("mem_access_ctrl: WAIT_CYCLES must be in 1..15");
  end

  state_t            state_reg, state_next;
  logic              write_reg;
  logic              addr_ok_reg;
  logic [DATA_W-1:0] mem_address_reg;
  logic [DATA_W-1:0] mem_data_in_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              mem_read_reg, mem_read_next;
  logic              mem_write_reg, mem_write_next;
  logic              done_reg, done_next;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              accept;
  logic              addr_in_range;
  logic [DATA_W-1:0] addr_trunc;

  // Only the RAM-index bits reach the RAM; upper address bits read as zero.
  always_comb begin
    addr_trunc         = '0;
    addr_trunc[AW-1:0] = req_addr[AW-1:0];
  end

`ifdef MEMCTRL_ADDR_CHECK_EN
  assign addr_in_range = (req_addr < DATA_W'(MEM_DEPTH));
`else
  assign addr_in_range = 1'b1;
`endif

  assign accept = (state_reg == IDLE) && req_valid;

  mem_wait_counter u_wait_counter (
    .clk      (clk),
    .clr      (clr),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (CNT_W'(WAIT_CYCLES - 1)),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state_reg)
      IDLE:   if (req_valid) state_next = SETUP;
      SETUP: begin
        cnt_load   = 1'b1;
        state_next = STROBE;
      end
      STROBE: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_next = HOLD;
      end
      HOLD:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Strobes and done come straight from flops so the RAM never sees decode glitches.
    mem_read_next  = (state_next == STROBE) && addr_ok_reg && !write_reg;
    mem_write_next = (state_next == STROBE) && addr_ok_reg && write_reg;
    done_next      = (state_next == HOLD);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg       <= IDLE;
      write_reg       <= 1'b0;
      addr_ok_reg     <= 1'b0;
      mem_address_reg <= '0;
      mem_data_in_reg <= '0;
      rdata_reg       <= '0;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      mem_read_reg  <= mem_read_next;
      mem_write_reg <= mem_write_next;
      done_reg      <= done_next;
      if (accept) begin
        write_reg       <= req_write;
        addr_ok_reg     <= addr_in_range;
        mem_address_reg <= addr_trunc;
        mem_data_in_reg <= req_write ? req_wdata : '0;
      end else if (state_reg == HOLD) begin
        mem_data_in_reg <= '0;
      end
      if ((state_reg == STROBE) && cnt_zero && !write_reg && addr_ok_reg) begin
        rdata_reg <= mem_data_out;
      end
    end
  end

`ifdef MEMCTRL_ADDR_CHECK_EN
  logic addr_err_reg;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      addr_err_reg <= 1'b0;
    end else begin
      addr_err_reg <= (state_next == HOLD) && !addr_ok_reg;
    end
  end

  assign addr_err = addr_err_reg;
`endif

  assign req_ready   = clr && (state_reg == IDLE);
  assign done        = done_reg;
  assign rdata       = rdata_reg;
  assign mem_address = mem_address_reg;
  assign mem_data_in = mem_data_in_reg;
  assign mem_read    = mem_read_reg;
  assign mem_write   = mem_write_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table on a WAIT_CYCLES=1 instance,
// plus hand sequences for WAIT_CYCLES=4, back-pressure and reset mid-access.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        sel;

  logic        ready1, done1, rd1, wr1, err1;
  logic [31:0] rdata1, addr1, din1, dout1;
  logic        ready4, done4, rd4, wr4, err4;
  logic [31:0] rdata4, addr4, din4, dout4;
  logic        valid1, valid4;

  logic        o_ready, o_done, o_rd, o_wr, o_err;
  logic [31:0] o_rdata, o_addr, o_din;

  logic [31:0] ram1 [512];
  logic [31:0] ram4 [512];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign valid1 = req_valid & ~sel;
  assign valid4 = req_valid & sel;

  mem_access_ctrl #(.DATA_W(32), .MEM_DEPTH(512), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .clr(clr), .req_valid(valid1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready1), .done(done1),
    .rdata(rdata1), .mem_address(addr1), .mem_data_in(din1), .mem_read(rd1),
    .mem_write(wr1),
`ifdef MEMCTRL_ADDR_CHECK_EN
    .addr_err(err1),
`endif
    .mem_data_out(dout1)
  );

  mem_access_ctrl #(.DATA_W(32), .MEM_DEPTH(512), .WAIT_CYCLES(4)) u_dut4 (
    .clk(clk), .clr(clr), .req_valid(valid4), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready4), .done(done4),
    .rdata(rdata4), .mem_address(addr4), .mem_data_in(din4), .mem_read(rd4),
    .mem_write(wr4),
`ifdef MEMCTRL_ADDR_CHECK_EN
    .addr_err(err4),
`endif
    .mem_data_out(dout4)
  );

`ifndef MEMCTRL_ADDR_CHECK_EN
  assign err1 = 1'b0;
  assign err4 = 1'b0;
`endif

  // Combinational-read RAM models
  assign dout1 = ram1[addr1[8:0]];
  assign dout4 = ram4[addr4[8:0]];
  always @(posedge clk) if (wr1) ram1[addr1[8:0]] <= din1;
  always @(posedge clk) if (wr4) ram4[addr4[8:0]] <= din4;

  assign o_ready = sel ? ready4 : ready1;
  assign o_done  = sel ? done4  : done1;
  assign o_rd    = sel ? rd4    : rd1;
  assign o_wr    = sel ? wr4    : wr1;
  assign o_err   = sel ? err4   : err1;
  assign o_rdata = sel ? rdata4 : rdata1;
  assign o_addr  = sel ? addr4  : addr1;
  assign o_din   = sel ? din4   : din1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One access: acceptance edge is cycle 0, each following negedge samples cycle c.
  task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output int rdc, output int wrc, output int first,
                           output logic [31:0] a_seen, output logic [31:0] d_seen,
                           output logic err_seen);
    lat = -1; rdc = 0; wrc = 0; first = -1;
    a_seen = '0; d_seen = '0; err_seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    check("ready_before_req", {31'b0, o_ready}, 32'd1);
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (o_rd) begin rdc++; if (first < 0) first = c; end
      if (o_wr) begin wrc++; if (first < 0) first = c; end
      if (o_done) begin
        lat = c; a_seen = o_addr; d_seen = o_din; err_seen = o_err;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rdc;
    int          wrc;
    logic [31:0] e_addr;
    logic [31:0] e_din;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int          lat, rdc, wrc, first, acc, lowc, donec;
    logic [31:0] a_seen, d_seen;
    logic        err_seen, pend;
    logic [31:0] strobe_addr [2];

    for (int i = 0; i < 512; i++) begin
      ram1[i] = 32'hA000_0000 + 32'(i);
      ram4[i] = 32'hA000_0000 + 32'(i);
    end
    ram1[9'h47] = 32'h94;
    ram4[9'h47] = 32'h94;

    vecs[0] = '{1'b0, 32'h47,  32'h0,        1, 0, 32'h47,  32'h0,        32'h94,        1'b0};
    vecs[1] = '{1'b1, 32'h8E,  32'h9,        0, 1, 32'h8E,  32'h9,        32'h94,        1'b0};
    vecs[2] = '{1'b0, 32'h8E,  32'h0,        1, 0, 32'h8E,  32'h0,        32'h9,         1'b0};
`ifdef MEMCTRL_ADDR_CHECK_EN
    vecs[3] = '{1'b0, 32'h205, 32'h0,        0, 0, 32'h005, 32'h0,        32'h9,         1'b1};
    vecs[4] = '{1'b1, 32'h1FF, 32'hDEADBEEF, 0, 1, 32'h1FF, 32'hDEADBEEF, 32'h9,         1'b0};
    vecs[5] = '{1'b0, 32'h1FF, 32'h0,        1, 0, 32'h1FF, 32'h0,        32'hDEADBEEF,  1'b0};
    vecs[6] = '{1'b1, 32'h200, 32'h55,       0, 0, 32'h000, 32'h55,       32'hDEADBEEF,  1'b1};
    vecs[7] = '{1'b0, 32'h000, 32'h0,        1, 0, 32'h000, 32'h0,        32'hA0000000,  1'b0};
`else
    vecs[3] = '{1'b0, 32'h205, 32'h0,        1, 0, 32'h005, 32'h0,        32'hA0000005,  1'b0};
    vecs[4] = '{1'b1, 32'h1FF, 32'hDEADBEEF, 0, 1, 32'h1FF, 32'hDEADBEEF, 32'hA0000005,  1'b0};
    vecs[5] = '{1'b0, 32'h1FF, 32'h0,        1, 0, 32'h1FF, 32'h0,        32'hDEADBEEF,  1'b0};
    vecs[6] = '{1'b1, 32'h200, 32'h55,       0, 1, 32'h000, 32'h55,       32'hDEADBEEF,  1'b0};
    vecs[7] = '{1'b0, 32'h000, 32'h0,        1, 0, 32'h000, 32'h0,        32'h55,        1'b0};
`endif

    sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    clr = 1'b1;
    #1 clr = 1'b0;
    #2;
    check("rst_mem_read",  {31'b0, o_rd},   32'd0);
    check("rst_mem_write", {31'b0, o_wr},   32'd0);
    check("rst_done",      {31'b0, o_done}, 32'd0);
    check("rst_rdata",     o_rdata, 32'd0);
    check("rst_mem_addr",  o_addr,  32'd0);
    check("rst_mem_din",   o_din,   32'd0);
    check("rst_err",       {31'b0, o_err},  32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    #1 check("rst_ready_after_release", {31'b0, o_ready}, 32'd1);

    // Table of single accesses on the WAIT_CYCLES=1 instance
    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rdc, wrc, first, a_seen, d_seen, err_seen);
      $display("txn %0d: %s addr=0x%08h wdata=0x%08h lat=%0d rd=%0d wr=%0d mem_addr=0x%08h rdata=0x%08h err=%0b",
               i, vecs[i].wr ? "store" : "load", vecs[i].addr, vecs[i].wdata, lat, rdc, wrc,
               a_seen, o_rdata, err_seen);
      check($sformatf("v%0d_latency", i),   32'(lat), 32'd3);
      check($sformatf("v%0d_read_cnt", i),  32'(rdc), 32'(vecs[i].rdc));
      check($sformatf("v%0d_write_cnt", i), 32'(wrc), 32'(vecs[i].wrc));
      check($sformatf("v%0d_mem_addr", i),  a_seen, vecs[i].e_addr);
      check($sformatf("v%0d_mem_din", i),   d_seen, vecs[i].e_din);
      check($sformatf("v%0d_rdata", i),     o_rdata, vecs[i].e_rdata);
      check($sformatf("v%0d_addr_err", i),  {31'b0, err_seen}, {31'b0, vecs[i].e_err});
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), {31'b0, o_done},  32'd0);
      check($sformatf("v%0d_idle_din", i),   o_din,             32'd0);
      check($sformatf("v%0d_idle_addr", i),  o_addr,            vecs[i].e_addr);
      check($sformatf("v%0d_idle_ready", i), {31'b0, o_ready}, 32'd1);
    end

    // WAIT_CYCLES=4 instance: four consecutive read cycles, done six cycles after acceptance
    sel = 1'b1;
    do_access(1'b0, 32'h47, 32'h0, lat, rdc, wrc, first, a_seen, d_seen, err_seen);
    $display("txn w4: load addr=0x00000047 lat=%0d rd=%0d first=%0d rdata=0x%08h", lat, rdc, first, o_rdata);
    check("w4_latency",   32'(lat),   32'd6);
    check("w4_read_cnt",  32'(rdc),   32'd4);
    check("w4_first_rd",  32'(first), 32'd2);
    check("w4_write_cnt", 32'(wrc),   32'd0);
    check("w4_rdata",     o_rdata,    32'h94);
    sel = 1'b0;

    // Back-pressure: req_valid held high across two accesses
    acc = 0; lowc = 0; rdc = 0; donec = 0; pend = 1'b0;
    strobe_addr[0] = '0; strobe_addr[1] = '0;
    @(negedge clk);
    req_write = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (!o_ready) lowc++;
      if (o_rd) begin
        if (rdc < 2) strobe_addr[rdc] = o_addr;
        rdc++;
      end
      if (o_done) donec++;
      if (pend) begin
        pend = 1'b0;
        if (acc == 1) req_addr = 32'h11;
        else req_valid = 1'b0;
      end
      if (o_ready && req_valid) begin acc++; pend = 1'b1; end
      @(negedge clk);
    end
    req_valid = 1'b0;
    $display("txn bp: accepted=%0d ready_low=%0d reads=%0d dones=%0d addrs=0x%08h,0x%08h",
             acc, lowc, rdc, donec, strobe_addr[0], strobe_addr[1]);
    check("bp_ready_low_cycles", 32'(lowc),  32'd6);
    check("bp_read_strobes",     32'(rdc),   32'd2);
    check("bp_done_pulses",      32'(donec), 32'd2);
    check("bp_addr0",            strobe_addr[0], 32'h10);
    check("bp_addr1",            strobe_addr[1], 32'h11);
    check("bp_rdata",            o_rdata,    32'hA0000011);

    // Reset asserted during the strobe of a store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_write_before_rst", {31'b0, o_wr}, 32'd1);
    #1 clr = 1'b0;
    #1;
    $display("txn rst: store addr=0x00000030 aborted, mem_write=%0b done=%0b ready=%0b", o_wr, o_done, o_ready);
    check("mid_write_dropped", {31'b0, o_wr},   32'd0);
    check("mid_rdata_reset",   o_rdata,         32'd0);
    check("mid_addr_reset",    o_addr,          32'd0);
    @(negedge clk);
    check("mid_no_done",       {31'b0, o_done}, 32'd0);
    clr = 1'b1;
    #1 check("mid_ready_release", {31'b0, o_ready}, 32'd1);
    check("mid_ram_untouched", ram1[9'h30], 32'hA0000030);

    do_access(1'b0, 32'h47, 32'h0, lat, rdc, wrc, first, a_seen, d_seen, err_seen);
    $display("txn post: load addr=0x00000047 lat=%0d rdata=0x%08h", lat, o_rdata);
    check("post_latency", 32'(lat), 32'd3);
    check("post_rdata",   o_rdata,  32'h94);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- CPU-side initiator for the word-addressed, 512-entry combinational RAM.
- Accepts load/store requests from the control unit through a valid/ready handshake.
- Sequences address setup, the read/write strobe and the hold phase so the RAM never sees a glitched write strobe.
- Captures read data into an internal MDR-style register and signals completion with a one-cycle done pulse.

Parameters:
- DATA_W, 32, data and address width.
- MEM_DEPTH, 512, number of RAM words; the legal address range is 0 to MEM_DEPTH-1.
- WAIT_CYCLES, 1, number of cycles the strobe stays asserted; legal range is 1 to 15, and 0 is illegal (elaboration error).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous, active-low reset.
- req_valid  in  1  control unit presents a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  DATA_W  word address.
- req_wdata  in  DATA_W  store data.
- req_ready  out  1  controller is idle and can accept a request.
- done  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  last loaded word.
- mem_address  out  DATA_W  to RAM address.
- mem_data_in  out  DATA_W  to RAM data_in.
- mem_read  out  1  to RAM read.
- mem_write  out  1  to RAM write.
- mem_data_out  in  DATA_W  from RAM data_out.

Behaviour:
- Reset (clr=0, asynchronous, also mid-operation):
  - state goes to IDLE.
  - mem_read, mem_write and done go to 0 immediately.
  - mem_address, mem_data_in and rdata go to 0.
  - req_ready goes to 1 once clr=1.
- FSM states are IDLE, SETUP, STROBE and HOLD.
- IDLE:
  - req_ready=1 and strobes are 0.
  - On a clk edge with req_valid=1, latch addr, wdata and write, then go to SETUP.
- SETUP (1 cycle):
  - mem_address is driven from the latched addr and strobes are 0.
  - On a store, mem_data_in is driven with wdata starting this cycle.
  - Go to STROBE and load the wait counter with WAIT_CYCLES-1.
- STROBE (WAIT_CYCLES cycles):
  - mem_write=1 for a store or mem_read=1 for a load; never both.
  - The counter decrements each cycle.
  - In the last strobe cycle (counter=0) of a load, rdata <= mem_data_out on the clock edge.
  - Then go to HOLD.
- HOLD (1 cycle):
  - Strobes are 0, while address and data are held.
  - done=1 for this cycle only; go to IDLE.
- Handshake rules:
  - req_ready=0 in SETUP, STROBE and HOLD.
  - req_valid is ignored while req_ready=0; there is no queueing.
  - A new request may be accepted in the IDLE cycle right after HOLD.
- Latency: with acceptance at edge 0, done is high during cycle WAIT_CYCLES+2 (cycle 3 for the default).
- rdata holds its value until the next completed load; stores and errors leave it unchanged.
- mem_data_in is 0 for loads and in IDLE.
- mem_address holds its last value in IDLE.
- Addressing, default build (wrap-around): mem_address carries only the low log2(MEM_DEPTH) bits of the latched addr, with the upper bits forced to 0. For example, addr 0x205 with depth 512 accesses word 0x005.

Optional Feature:
- Macro: MEMCTRL_ADDR_CHECK_EN.
- When defined:
  - Adds output port addr_err (1 bit, reset 0).
  - If the latched addr >= MEM_DEPTH, STROBE is entered but neither strobe asserts.
  - addr_err pulses with done in HOLD; rdata and RAM contents are unchanged.
  - Latency is identical to a normal access.
- When undefined: there is no addr_err port and the wrap-around truncation rule applies.

Decomposition:
- Package mem_ctrl_pkg holds:
  - the FSM state enum (IDLE, SETUP, STROBE, HOLD);
  - DATA_W and MEM_DEPTH defaults;
  - localparam ADDR_BITS = clog2(MEM_DEPTH).
- One sub-module, mem_wait_counter: a loadable 4-bit down-counter with a zero flag that drives the STROBE exit.

Test Plan:
- Reset and load latency:
  - Stimulus: clr=0 then 1; preload RAM[0x47]=0x94; load at 0x47.
  - Response: mem_read=1 for exactly 1 cycle; done in cycle 3 after acceptance; rdata=0x00000094.
- Store then load:
  - Stimulus: store 0x00000009 to 0x8E, then load 0x8E.
  - Response: mem_write high for exactly 1 cycle with mem_data_in=9; the load returns 9; rdata is unchanged by the store itself.
- Busy back-pressure:
  - Stimulus: hold req_valid=1 continuously with addr 0x10 then 0x11.
  - Response: req_ready is low for 3 cycles per access; exactly two accesses occur; no extra strobe.
- Parameter WAIT_CYCLES=4:
  - Stimulus: load 0x47.
  - Response: mem_read is high for 4 consecutive cycles; done arrives 6 cycles after acceptance.
- Reset mid-operation:
  - Stimulus: assert clr=0 during STROBE of a store.
  - Response: mem_write drops asynchronously the same instant; no done pulse; req_ready=1 after release.
- Out-of-range address:
  - Default build: load 0x205 drives mem_address=0x005.
  - With MEMCTRL_ADDR_CHECK_EN: store to 0x200 gives no mem_write, and addr_err=1 together with done.
